dice_roll_sequencer: RTL

DICE_ROLL_SEQUENCER -- requirements
Module: dice_roll_sequencer

---
 rtl/dice_pkg.sv | 25 ++
 rtl/dice_face_lut.sv | 23 ++
 rtl/dice_roll_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types and widths for the dice roll sequencer.
package dice_pkg;

  localparam int SUM_W   = 11;
  localparam int VALUE_W = 7;

  typedef enum logic [2:0] {
    DIE_D4      = 3'd0,
    DIE_D6      = 3'd1,
    DIE_D8      = 3'd2,
    DIE_D10     = 3'd3,
    DIE_D12     = 3'd4,
    DIE_D20     = 3'd5,
    DIE_D100    = 3'd6,
    DIE_INVALID = 3'd7
  } die_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dice_face_lut.sv
// Die code to face count; invalid code maps to 0.
module dice_face_lut
  import dice_pkg::*;
(
  input  die_e               die,
  output logic [VALUE_W-1:0] faces
);

  always_comb begin
    faces = '0;
    case (die)
      DIE_D4:   faces = 7'd4;
      DIE_D6:   faces = 7'd6;
      DIE_D8:   faces = 7'd8;
      DIE_D10:  faces = 7'd10;
      DIE_D12:  faces = 7'd12;
      DIE_D20:  faces = 7'd20;
      DIE_D100: faces = 7'd100;
      default:  faces = '0;
    endcase
  end

endmodule

// File: rtl/dice_roll_sequencer.sv
// Requests N rolls from an external generator, accumulating the sum and
// natural-max/min/error flags; timeout is a down-counter per requested roll.
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         die_sel,
  input  logic [COUNT_W-1:0] dice_count,
  input  logic               abort,
  output logic               roll_req,
  output logic [2:0]         roll_die,
  input  logic               roll_ack,
  input  logic [VALUE_W-1:0] roll_value,
  output logic [SUM_W-1:0]   sum,
  output logic               done,
  output logic               busy,
  output logic               nat_max,
  output logic               nat_min,
  output logic               err
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e               state, state_nxt;
  die_e                 die_q;
  logic [COUNT_W-1:0]   remaining;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [VALUE_W-1:0]   faces;
  logic [VALUE_W-1:0]   clamped;
  logic [SUM_W:0]       sum_wide;
  logic [SUM_W-1:0]     sum_add;
  logic                 val_ok;
  logic                 launch;
  logic                 accept;
  logic                 tmo_hit;

  dice_face_lut u_lut (
    .die   (die_q),
    .faces (faces)
  );

  assign roll_die = die_q;
  assign busy     = (state != S_IDLE);
  assign launch   = (state == S_IDLE) && start && !abort;

  // Out-of-range faces (including 0) are replaced by the face count
  assign val_ok   = (roll_value != '0) && (roll_value <= faces);
  assign clamped  = val_ok ? roll_value : faces;
  assign sum_wide = {1'b0, sum} + {{(SUM_W + 1 - VALUE_W){1'b0}}, clamped};
  assign sum_add  = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    roll_req  = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (die_e'(die_sel) == DIE_INVALID) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        roll_req = 1'b1;
        if (roll_ack) begin
          accept    = !abort;
          state_nxt = (remaining == COUNT_W'(1)) ? S_DONE : S_GAP;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = !abort;
          state_nxt = S_DONE;
        end
      end
      S_GAP:  state_nxt = S_REQ;
      S_DONE: begin
        done      = !abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      die_q     <= DIE_D4;
      remaining <= '0;
      tmo_cnt   <= '0;
      sum       <= '0;
      nat_max   <= 1'b0;
      nat_min   <= 1'b0;
      err       <= 1'b0;
    end else if (launch) begin
      die_q     <= die_e'(die_sel);
      remaining <= (dice_count == '0) ? COUNT_W'(1) : dice_count;
      tmo_cnt   <= TMO_LOAD;
      sum       <= '0;
      nat_max   <= 1'b0;
      nat_min   <= 1'b0;
      err       <= (die_e'(die_sel) == DIE_INVALID);
    end else if (accept) begin
      sum       <= sum_add;
      remaining <= remaining - COUNT_W'(1);
      tmo_cnt   <= TMO_LOAD;
      if (!val_ok)               err     <= 1'b1;
      if (roll_value == faces)   nat_max <= 1'b1;
      if (roll_value == 7'd1)    nat_min <= 1'b1;
    end else if (tmo_hit) begin
      err       <= 1'b1;
    end else if (state == S_REQ && !abort && !roll_ack) begin
      tmo_cnt   <= tmo_cnt - TMO_W'(1);
    end
  end

endmodule
